add_chunk_ctrl: RTL

ADD_CHUNK_CTRL -- requirements
Module: add_chunk_ctrl

---
 rtl/add_chunk_ctrl.sv | 73 +++++++
 1 files changed

// File: rtl/add_chunk_ctrl.sv
// add_chunk_ctrl: multi-cycle adder that adds W = N*K bit operands one N-bit chunk per cycle.
module add_chunk_ctrl #(
    parameter int N = 4,
    parameter int K = 4,
    localparam int W = N * K,
    localparam int IW = (K > 1) ? $clog2(K) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  x_reg, y_reg;
    logic [N:0]    chunk;
    assign chunk = {1'b0, x_reg[idx*N +: N]} + {1'b0, y_reg[idx*N +: N]} + {{N{1'b0}}, carry};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_reg    <= x;
                    y_reg    <= y;
                    carry    <= c_in;
                    idx      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    sum[idx*N +: N] <= chunk[N-1:0];
                    carry           <= chunk[N];
                    if (idx == IW'(K - 1)) begin
                        c_out     <= chunk[N];
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: if (out_ready) begin
                    // in_ready rises only after this edge, so no accept can share the handshake cycle
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
